// File: rtl/rx_fifo.sv
// rx_fifo: receive buffer between the UART receiver and the host.
// Captures {error, data} on each rising edge of Data_Rdy_In into a circular
// FIFO and returns entries through a registered read port with a 1-cycle
// Rd_Valid pulse. RTS_Out throttles the far end when the FIFO is almost full.
// Ports:
//   Clk, Rst                     clock, asynchronous active-high reset
//   Data_Rdy_In, Rx_Data_In,
//   Rx_Error_In, Rx_RTS_In       receiver side
//   Rd_En, Clr_Ovf               host controls
//   Rd_Data, Rd_Error, Rd_Valid  registered read port
//   Empty, Full, Almost_Full,
//   Count, Overflow              status (decoded from registered state)
//   RTS_Out                      combinational flow-control output
module rx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned AF_THRESH  = 12
) (
    input  logic                               Clk,
    input  logic                               Rst,
    input  logic                               Data_Rdy_In,
    input  logic [DATA_BITS-1:0]               Rx_Data_In,
    input  logic [2:0]                         Rx_Error_In,
    input  logic                               Rx_RTS_In,
    input  logic                               Rd_En,
    input  logic                               Clr_Ovf,
    output logic [DATA_BITS-1:0]               Rd_Data,
    output logic [2:0]                         Rd_Error,
    output logic                               Rd_Valid,
    output logic                               Empty,
    output logic                               Full,
    output logic                               Almost_Full,
    output logic [$clog2(FIFO_DEPTH):0]        Count,
    output logic                               Overflow,
    output logic                               RTS_Out
);

    localparam int unsigned ADDR_BITS  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_BITS   = ADDR_BITS + 1;
    localparam int unsigned ENTRY_BITS = DATA_BITS + 3;

    logic [ENTRY_BITS-1:0] mem_q [FIFO_DEPTH];

    logic                  dly_rdy_q,  dly_rdy_d;
    logic [ADDR_BITS-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [ADDR_BITS-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [CNT_BITS-1:0]   count_q,    count_d;
    logic [DATA_BITS-1:0]  rd_data_q,  rd_data_d;
    logic [2:0]            rd_error_q, rd_error_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;

    logic                  push_req;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  empty_c;
    logic                  full_c;
    logic [ENTRY_BITS-1:0] wr_entry;

    // Status flags decoded from the registered occupancy
    assign empty_c = (count_q == CNT_BITS'(0));
    assign full_c  = (count_q == CNT_BITS'(FIFO_DEPTH));

    // Push on the rising edge of Data_Rdy_In; a full FIFO still accepts a
    // push when a pop frees a slot in the same cycle
    assign push_req = Data_Rdy_In & ~dly_rdy_q;
    assign pop_ok   = Rd_En & ~empty_c;
    assign push_ok  = push_req & (~full_c | pop_ok);
    assign wr_entry = {Rx_Error_In, Rx_Data_In};

    // Next-state logic
    always_comb begin
        dly_rdy_d  = Data_Rdy_In;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_error_d = rd_error_q;
        rd_valid_d = pop_ok;
        overflow_d = overflow_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
        end

        if (pop_ok) begin
            {rd_error_d, rd_data_d} = mem_q[rd_ptr_q];
            rd_ptr_d                = rd_ptr_q + ADDR_BITS'(1);
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase

        // A dropped push beats a same-cycle clear
        if (push_req & ~push_ok) begin
            overflow_d = 1'b1;
        end else if (Clr_Ovf) begin
            overflow_d = 1'b0;
        end
    end

    // Control and read-port registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            dly_rdy_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_error_q <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            dly_rdy_q  <= dly_rdy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_error_q <= rd_error_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset. On a full push+pop wr_ptr == rd_ptr; the read
    // above samples the old entry, so the incoming word never falls through.
    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign Rd_Data     = rd_data_q;
    assign Rd_Error    = rd_error_q;
    assign Rd_Valid    = rd_valid_q;
    assign Empty       = empty_c;
    assign Full        = full_c;
    assign Almost_Full = (count_q >= CNT_BITS'(AF_THRESH));
    assign Count       = count_q;
    assign Overflow    = overflow_q;
    assign RTS_Out     = Rx_RTS_In & ~Almost_Full;

endmodule
